// File: rtl/ins_exec_rv32i_ctrl_xfer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_pkg
//  Brief    : Opcode/funct3 constants and the registered control-transfer
//             result record shared by the execute-stage control-transfer unit.
//  Revision : 1.0  initial release
// ============================================================================
package rv32i_pkg;

    // Widest supported datapath; narrower XLEN uses the low bits of each field.
    localparam int c_XLEN_MAX = 64;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic                  pc_w_op;
        logic [c_XLEN_MAX-1:0] pc_w_val;
        logic                  w_op;
        logic [4:0]            w_idx;
        logic [c_XLEN_MAX-1:0] w_val;
        logic                  exc_mis;
        logic                  exc_ill;
        logic [c_XLEN_MAX-1:0] tval;
    } ctrl_xfer_res_t;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/ins_exec_rv32i_ctrl_xfer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ins_exec_rv32i_ctrl_xfer_if
//  Brief    : Request/result bundle between register-read, the control-transfer
//             unit and the PC / register-file write ports.
//  Revision : 1.0  initial release
// ============================================================================
interface ins_exec_rv32i_ctrl_xfer_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      ins_dec_op;
    logic [2:0]      ins_dec_funct3;
    logic [XLEN-1:0] reg_rs1_val;
    logic [XLEN-1:0] reg_rs2_val;
    logic [XLEN-1:0] reg_pc_val;
    logic [4:0]      reg_rd;
    logic [XLEN-1:0] imm_ext_ext;

    logic            out_valid;
    logic            out_ready;
    logic            reg_pc_w_op;
    logic [XLEN-1:0] reg_pc_w_val;
    logic            reg_w_op;
    logic [4:0]      reg_w_reg_idx;
    logic [XLEN-1:0] reg_w_reg_val;
    logic            exc_misaligned;
    logic            exc_illegal;
    logic [XLEN-1:0] exc_tval;

    modport master (
        output in_valid, ins_dec_op, ins_dec_funct3, reg_rs1_val, reg_rs2_val,
               reg_pc_val, reg_rd, imm_ext_ext, out_ready,
        input  in_ready, out_valid, reg_pc_w_op, reg_pc_w_val, reg_w_op,
               reg_w_reg_idx, reg_w_reg_val, exc_misaligned, exc_illegal, exc_tval
    );

    modport slave (
        input  in_valid, ins_dec_op, ins_dec_funct3, reg_rs1_val, reg_rs2_val,
               reg_pc_val, reg_rd, imm_ext_ext, out_ready,
        output in_ready, out_valid, reg_pc_w_op, reg_pc_w_val, reg_w_op,
               reg_w_reg_idx, reg_w_reg_val, exc_misaligned, exc_illegal, exc_tval
    );

endinterface : ins_exec_rv32i_ctrl_xfer_if
`default_nettype wire

// File: rtl/ins_exec_rv32i_ctrl_xfer_branch_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_xfer_branch_cmp
//  Brief    : Combinational RV32I branch condition evaluator (taken / illegal).
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_xfer_branch_cmp
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [2:0]      i_funct3,
    input  wire logic [XLEN-1:0] i_rs1,
    input  wire logic [XLEN-1:0] i_rs2,
    output logic                 o_taken,
    output logic                 o_illegal
);

    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = (i_rs1 == i_rs2);
            F3_BNE:  o_taken = (i_rs1 != i_rs2);
            F3_BLT:  o_taken = ($signed(i_rs1) <  $signed(i_rs2));
            F3_BGE:  o_taken = ($signed(i_rs1) >= $signed(i_rs2));
            F3_BLTU: o_taken = (i_rs1 <  i_rs2);
            F3_BGEU: o_taken = (i_rs1 >= i_rs2);
            default: o_illegal = 1'b1;
        endcase
    end

endmodule : ctrl_xfer_branch_cmp
`default_nettype wire

// File: rtl/ins_exec_rv32i_ctrl_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : ins_exec_rv32i_ctrl_xfer
//  Brief    : Registered JAL/JALR/branch execution with one-entry result
//             buffer, misalignment/illegal detection and taken counter.
//  Revision : 1.0  initial release
// ============================================================================
module ins_exec_rv32i_ctrl_xfer
    import rv32i_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALLOW_C = 0,
    parameter int CNT_W   = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 flush,
    ins_exec_rv32i_ctrl_xfer_if.slave bus,
    output logic [CNT_W-1:0]          taken_cnt
);

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            w_out_valid;
    logic            w_accept;
    logic            w_drain;

    ctrl_xfer_res_t  w_res;
    ctrl_xfer_res_t  r_res;
    logic [CNT_W-1:0] r_taken_cnt;

    logic            w_cmp_taken;
    logic            w_cmp_illegal;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_is_branch;
    logic            w_taken;
    logic            w_mis_bit;
    logic [XLEN-1:0] w_pc_tgt;
    logic [XLEN-1:0] w_jalr_tgt;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_link;

    // ------------------------------------------------------------------ handshake
    assign bus.in_ready = !w_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready && !flush;
    assign w_drain      = w_out_valid && bus.out_ready;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_accept) w_state_nxt = c_ST_FULL;
            end
            c_ST_FULL: begin
                if (flush)                    w_state_nxt = c_ST_EMPTY;
                else if (w_accept)            w_state_nxt = c_ST_FULL;
                else if (w_drain)             w_state_nxt = c_ST_EMPTY;
            end
            default: w_state_nxt = c_ST_EMPTY;
        endcase
    end

    always_comb begin
        w_out_valid = (r_state == c_ST_FULL);
    end

    assign bus.out_valid = w_out_valid;

    // ------------------------------------------------------------------ decode
    ctrl_xfer_branch_cmp #(
        .XLEN (XLEN)
    ) u_branch_cmp (
        .i_funct3  (bus.ins_dec_funct3),
        .i_rs1     (bus.reg_rs1_val),
        .i_rs2     (bus.reg_rs2_val),
        .o_taken   (w_cmp_taken),
        .o_illegal (w_cmp_illegal)
    );

    assign w_is_jal    = (bus.ins_dec_op == OP_JAL);
    assign w_is_jalr   = (bus.ins_dec_op == OP_JALR) && (bus.ins_dec_funct3 == 3'b000);
    assign w_is_branch = (bus.ins_dec_op == OP_BRANCH) && !w_cmp_illegal;

    assign w_pc_tgt   = bus.reg_pc_val + bus.imm_ext_ext;
    assign w_jalr_tgt = (bus.reg_rs1_val + bus.imm_ext_ext) & ~XLEN'(1);
    assign w_target   = w_is_jalr ? w_jalr_tgt : w_pc_tgt;
    // Link is taken from the instruction PC, so rd==rs1 cannot corrupt it.
    assign w_link     = bus.reg_pc_val + XLEN'(4);

    assign w_taken = w_is_jal || w_is_jalr || (w_is_branch && w_cmp_taken);

    generate
        if (ALLOW_C != 0) begin : g_align_half
            assign w_mis_bit = w_target[0];
        end else begin : g_align_word
            assign w_mis_bit = w_target[1];
        end
    endgenerate

    always_comb begin
        w_res = '0;
        if (!(w_is_jal || w_is_jalr || w_is_branch)) begin
            w_res.exc_ill = 1'b1;
        end else if (w_taken && w_mis_bit) begin
            w_res.exc_mis = 1'b1;
            w_res.tval    = c_XLEN_MAX'(w_target);
        end else begin
            w_res.pc_w_op  = w_taken;
            w_res.pc_w_val = w_taken ? c_XLEN_MAX'(w_target) : '0;
            if (w_is_jal || w_is_jalr) begin
                w_res.w_op  = (bus.reg_rd != 5'd0);
                w_res.w_idx = bus.reg_rd;
                w_res.w_val = c_XLEN_MAX'(w_link);
            end
        end
    end

    // ------------------------------------------------------------------ result register
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_res <= '0;
        end else if (w_accept) begin
            r_res <= w_res;
        end
    end

    assign bus.reg_pc_w_op    = r_res.pc_w_op;
    assign bus.reg_pc_w_val   = r_res.pc_w_val[XLEN-1:0];
    assign bus.reg_w_op       = r_res.w_op;
    assign bus.reg_w_reg_idx  = r_res.w_idx;
    assign bus.reg_w_reg_val  = r_res.w_val[XLEN-1:0];
    assign bus.exc_misaligned = r_res.exc_mis;
    assign bus.exc_illegal    = r_res.exc_ill;
    assign bus.exc_tval       = r_res.tval[XLEN-1:0];

    generate
        if (XLEN < c_XLEN_MAX) begin : g_hi_sink
            logic w_unused_hi;
            assign w_unused_hi = ^{r_res.pc_w_val[c_XLEN_MAX-1:XLEN],
                                   r_res.w_val[c_XLEN_MAX-1:XLEN],
                                   r_res.tval[c_XLEN_MAX-1:XLEN]};
        end
    endgenerate

    // ------------------------------------------------------------------ taken counter
    // A flush kills the held result, so a same-cycle handshake does not retire it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_taken_cnt <= '0;
        end else if (w_drain && !flush && r_res.pc_w_op && (r_taken_cnt != '1)) begin
            r_taken_cnt <= r_taken_cnt + CNT_W'(1);
        end
    end

    assign taken_cnt = r_taken_cnt;

endmodule : ins_exec_rv32i_ctrl_xfer
`default_nettype wire

// File: tb/tb_ins_exec_rv32i_ctrl_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ins_exec_rv32i_ctrl_xfer
//  Brief    : Directed self-checking bench; word-aligned and half-aligned
//             instances share one stimulus stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ins_exec_rv32i_ctrl_xfer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    logic [4:0]  rd;
    logic [31:0] cnt0, cnt1;
    logic [31:0] held;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ins_exec_rv32i_ctrl_xfer_if #(.XLEN(32)) bus0 ();
    ins_exec_rv32i_ctrl_xfer_if #(.XLEN(32)) bus1 ();

    assign bus0.in_valid = in_valid;   assign bus1.in_valid = in_valid;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;
    assign bus0.ins_dec_op = op;       assign bus1.ins_dec_op = op;
    assign bus0.ins_dec_funct3 = f3;   assign bus1.ins_dec_funct3 = f3;
    assign bus0.reg_rs1_val = rs1;     assign bus1.reg_rs1_val = rs1;
    assign bus0.reg_rs2_val = rs2;     assign bus1.reg_rs2_val = rs2;
    assign bus0.reg_pc_val = pc;       assign bus1.reg_pc_val = pc;
    assign bus0.reg_rd = rd;           assign bus1.reg_rd = rd;
    assign bus0.imm_ext_ext = imm;     assign bus1.imm_ext_ext = imm;

    ins_exec_rv32i_ctrl_xfer #(.XLEN(32), .ALLOW_C(0), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0), .taken_cnt(cnt0)
    );

    ins_exec_rv32i_ctrl_xfer #(.XLEN(32), .ALLOW_C(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1), .taken_cnt(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [6:0] o, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] p, input logic [4:0] d,
                           input logic [31:0] i);
        op = o; f3 = f; rs1 = a; rs2 = b; pc = p; rd = d; imm = i;
    endtask

    // Present one request for one edge; the result is visible on return.
    task automatic issue(input logic [6:0] o, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [4:0] d,
                         input logic [31:0] i);
        set_req(o, f, a, b, p, d, i);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_req(7'd0, 3'd0, 0, 0, 0, 5'd0, 0);
        tick(); tick();
        check("rst_out_valid", 32'(bus0.out_valid), 0);
        check("rst_taken_cnt", cnt0, 0);
        check("rst_pc_w_val", bus0.reg_pc_w_val, 0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 32'(bus0.in_ready), 1);

        // JAL pc=0x100 imm=0x20 rd=1
        issue(7'b1101111, 3'd0, 0, 0, 'h100, 5'd1, 'h20);
        check("jal_out_valid", 32'(bus0.out_valid), 1);
        check("jal_pc_w_op", 32'(bus0.reg_pc_w_op), 1);
        check("jal_pc_w_val", bus0.reg_pc_w_val, 'h120);
        check("jal_w_op", 32'(bus0.reg_w_op), 1);
        check("jal_w_idx", 32'(bus0.reg_w_reg_idx), 1);
        check("jal_w_val", bus0.reg_w_reg_val, 'h104);
        check("jal_cnt_before_drain", cnt0, 0);
        tick();
        check("jal_cnt_after_drain", cnt0, 1);
        check("jal_drained", 32'(bus0.out_valid), 0);

        // JALR rs1=0x203 imm=4 rd=5: 0x206 faults word-aligned, fine half-aligned
        issue(7'b1100111, 3'd0, 'h203, 0, 'h300, 5'd5, 'h4);
        check("jalr_w_mis", 32'(bus0.exc_misaligned), 1);
        check("jalr_w_tval", bus0.exc_tval, 'h206);
        check("jalr_w_pc_op", 32'(bus0.reg_pc_w_op), 0);
        check("jalr_w_w_op", 32'(bus0.reg_w_op), 0);
        check("jalr_c_mis", 32'(bus1.exc_misaligned), 0);
        check("jalr_c_pc_op", 32'(bus1.reg_pc_w_op), 1);
        check("jalr_c_pc_val", bus1.reg_pc_w_val, 'h206);
        check("jalr_c_w_val", bus1.reg_w_reg_val, 'h304);
        check("jalr_c_w_idx", 32'(bus1.reg_w_reg_idx), 5);
        tick();
        check("jalr_w_cnt", cnt0, 1);
        check("jalr_c_cnt", cnt1, 2);

        // BLT -1 < 1 signed: taken
        issue(7'b1100011, 3'b100, 'hFFFF_FFFF, 1, 'h400, 5'd7, 'h10);
        check("blt_pc_op", 32'(bus0.reg_pc_w_op), 1);
        check("blt_pc_val", bus0.reg_pc_w_val, 'h410);
        check("blt_w_op", 32'(bus0.reg_w_op), 0);
        check("blt_w_idx", 32'(bus0.reg_w_reg_idx), 0);
        tick();
        check("blt_cnt", cnt0, 2);

        // BLTU 0xFFFFFFFF < 1 unsigned: not taken, misaligned target ignored
        issue(7'b1100011, 3'b110, 'hFFFF_FFFF, 1, 'h400, 5'd0, 'h6);
        check("bltu_pc_op", 32'(bus0.reg_pc_w_op), 0);
        check("bltu_pc_val", bus0.reg_pc_w_val, 0);
        check("bltu_mis", 32'(bus0.exc_misaligned), 0);
        tick();
        check("bltu_cnt", cnt0, 2);

        // BGE -2 >= -3 signed: taken; BNE equal: not taken
        issue(7'b1100011, 3'b101, 'hFFFF_FFFE, 'hFFFF_FFFD, 'h800, 5'd0, 'hFFFF_FFF0);
        check("bge_pc_val", bus0.reg_pc_w_val, 'h7F0);
        tick();
        issue(7'b1100011, 3'b001, 'h55, 'h55, 'h800, 5'd0, 'h8);
        check("bne_pc_op", 32'(bus0.reg_pc_w_op), 0);
        tick();
        check("bge_bne_cnt", cnt0, 3);

        // JAL rd=0, negative offset wraps to 0x4F8
        issue(7'b1101111, 3'd0, 0, 0, 'h500, 5'd0, 'hFFFF_FFF8);
        check("jal0_pc_op", 32'(bus0.reg_pc_w_op), 1);
        check("jal0_pc_val", bus0.reg_pc_w_val, 'h4F8);
        check("jal0_w_op", 32'(bus0.reg_w_op), 0);
        tick();
        check("jal0_cnt", cnt0, 4);

        // Illegal: BRANCH funct3=010 and JALR funct3!=0
        issue(7'b1100011, 3'b010, 0, 0, 'h600, 5'd0, 'h8);
        check("ill_br", 32'(bus0.exc_illegal), 1);
        check("ill_br_pc_op", 32'(bus0.reg_pc_w_op), 0);
        tick();
        issue(7'b1100111, 3'b001, 'h100, 0, 'h600, 5'd3, 'h8);
        check("ill_jalr", 32'(bus0.exc_illegal), 1);
        check("ill_jalr_w_op", 32'(bus0.reg_w_op), 0);
        tick();
        check("ill_cnt", cnt0, 4);

        // Back-pressure: hold 3 cycles, then drain+accept together
        out_ready = 1'b0;
        issue(7'b1101111, 3'd0, 0, 0, 'h600, 5'd2, 'h40);
        set_req(7'b1101111, 3'd0, 0, 0, 'h700, 5'd3, 'h8);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("stall_in_ready", 32'(bus0.in_ready), 0);
            check("stall_pc_val", bus0.reg_pc_w_val, 'h640);
            tick();
        end
        check("stall_valid", 32'(bus0.out_valid), 1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("swap_valid", 32'(bus0.out_valid), 1);
        check("swap_pc_val", bus0.reg_pc_w_val, 'h708);
        check("swap_w_idx", 32'(bus0.reg_w_reg_idx), 3);
        check("swap_cnt", cnt0, 5);
        tick();
        check("swap_cnt_drain", cnt0, 6);

        // Flush while FULL with a pending request
        issue(7'b1101111, 3'd0, 0, 0, 'h900, 5'd4, 'h10);
        held = cnt0;
        set_req(7'b1101111, 3'd0, 0, 0, 'hA00, 5'd6, 'h10);
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_valid", 32'(bus0.out_valid), 0);
        check("flush_cnt", cnt0, held);
        tick();
        check("flush_no_accept", 32'(bus0.out_valid), 0);

        // Reset mid-stream
        issue(7'b1101111, 3'd0, 0, 0, 'hB00, 5'd8, 'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(bus0.out_valid), 0);
        check("mid_rst_pc_val", bus0.reg_pc_w_val, 0);
        check("mid_rst_w_val", bus0.reg_w_reg_val, 0);
        check("mid_rst_cnt", cnt0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ins_exec_rv32i_ctrl_xfer
`default_nettype wire

// File: doc/ins_exec_rv32i_ctrl_xfer.md
Name: ins_exec_rv32i_ctrl_xfer

Overview:
- Registered control-transfer execution unit for the RV32I execute stage. It covers JAL, JALR and all six conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- Sits between the decoder/register-read stage and the PC and register-file write ports.
- Uses a valid/ready handshake and a one-entry output register.
- Detects misaligned targets and illegal funct3 values, and keeps a taken-transfer counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate, results).
- ALLOW_C, 0, 1 relaxes target alignment from 4 bytes to 2 bytes (compressed-ISA readiness).
- CNT_W, 32, width of taken-transfer counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline kill; drops held result and any same-cycle accept
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- ins_dec_op  in  7  decoded opcode
- ins_dec_funct3  in  3  decoded funct3
- reg_rs1_val  in  XLEN  rs1 value
- reg_rs2_val  in  XLEN  rs2 value
- reg_pc_val  in  XLEN  PC of the instruction
- reg_rd  in  5  destination register index
- imm_ext_ext  in  XLEN  sign-extended byte-offset immediate (J, I or B format, already scaled)
- out_valid  out  1  result register valid
- out_ready  in  1  consumer accepts result
- reg_pc_w_op  out  1  redirect PC
- reg_pc_w_val  out  XLEN  redirect target
- reg_w_op  out  1  write rd
- reg_w_reg_idx  out  5  rd index
- reg_w_reg_val  out  XLEN  link value
- exc_misaligned  out  1  instruction-address-misaligned exception
- exc_illegal  out  1  unsupported opcode/funct3
- exc_tval  out  XLEN  offending target (misaligned) or 0
- taken_cnt  out  CNT_W  count of retired taken transfers

Behaviour:
- Reset (rst=1 at posedge): out_valid=0; all result outputs and exc_* cleared to 0; taken_cnt=0. Reset takes priority over flush and handshakes.
- in_ready = !out_valid || out_ready (combinational). Accept when in_valid && in_ready && !flush.
- Latency: the result is registered and appears on the cycle after accept. Throughput is 1 per cycle when out_ready is held high.
- out_valid holds with all outputs stable until out_ready=1. An accept and a drain in the same cycle load the new result.
- flush=1: out_valid<=0 next cycle and the request in that cycle is not accepted. taken_cnt is unaffected.
- Decode on accept:
  - JAL (1101111): target = pc + imm; taken.
  - JALR (1100111, funct3=0): target = (rs1 + imm) & ~1; taken.
  - BRANCH (1100011): taken per funct3. 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. target = pc + imm.
  - Any other opcode, JALR funct3!=0, or BRANCH funct3 010/011: exc_illegal=1, no writes.
- Additions wrap modulo 2^XLEN.
- Misalignment: fault if target[1] (ALLOW_C=0) or target[0] (ALLOW_C=1; JALR bit0 already cleared).
  - Checked only when taken. A not-taken branch never faults.
  - On fault: exc_misaligned=1, exc_tval=target, reg_pc_w_op=0, reg_w_op=0.
- Taken, no fault: reg_pc_w_op=1, reg_pc_w_val=target.
- Not-taken branch: reg_pc_w_op=0, reg_pc_w_val=0.
- Link (JAL/JALR, no fault): reg_w_reg_val=pc+4, reg_w_reg_idx=rd, reg_w_op=(rd!=0). Link uses the original pc even when rd==rs1.
- Branches: reg_w_op=0, idx=0, val=0.
- taken_cnt increments by 1 on the cycle a result with reg_pc_w_op=1 is drained (out_valid && out_ready). It saturates at all-ones.
- Two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY->FULL on accept.
  - FULL->EMPTY on drain with no accept, or on flush.
  - FULL->FULL on stall, or on drain plus accept.

Decomposition:
- Shared package rv32i_pkg:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH
  - funct3 constants F3_BEQ..F3_BGEU
  - struct ctrl_xfer_res_t {pc_w_op, pc_w_val, w_op, w_idx, w_val, exc_mis, exc_ill, tval}
- One sub-module: ctrl_xfer_branch_cmp, a combinational funct3 comparator returning taken/illegal.

Test Plan:
- JAL pc=0x100, imm=0x20, rd=1, out_ready=1 -> next cycle out_valid=1, pc_w_val=0x120, w_idx=1, w_val=0x104, taken_cnt=1 after drain.
- JALR rs1=0x203, imm=0x4, rd=5 -> target 0x206 & ~1 = 0x206. With ALLOW_C=0: exc_misaligned=1, exc_tval=0x206, no writes. With ALLOW_C=1: pc_w_val=0x206.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken, pc_w_op=0, no exception even if pc+imm is misaligned.
- out_ready=0 for 3 cycles with FULL, new in_valid held -> in_ready=0, outputs stable. out_ready=1 -> drain and accept in the same cycle, next result valid.
- JAL with rd=0 -> reg_w_op=0, pc_w_op=1. BRANCH funct3=010 -> exc_illegal=1.
- flush while FULL with in_valid=1 -> out_valid=0 next cycle, request not accepted, taken_cnt unchanged. rst mid-stream -> all outputs 0 next cycle.
